// File: rtl/lt24_pixel_port.sv
// LT24 pixel responder: turns accepted (x, y, pixel) requests into 8080-style panel bus writes.
// Define LT24_PIXEL_STREAM_EN to stream address-sequential pixels as single data writes.
module lt24_pixel_port #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        addrError,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic [15:0] LT24Data
);
  localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);
  localparam logic [7:0]  LO_END   = 8'(WR_LOW - 1);
  localparam logic [7:0]  HI_END   = 8'(WR_HIGH - 1);
  localparam logic [3:0]  SLOT_PIX = 4'd11;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pix_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WR_LO, S_WR_HI, S_DONE} state_t;

  state_t      state, state_d;
  pix_t        pix_q;
  logic [3:0]  slot_q, slot_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept, oor, stream_hit;
  logic [15:0] x16, y16;
  logic        ready_d, err_d, wr_n_d, cs_n_d, rs_d;
  logic [15:0] data_d;

  assign x16      = {8'd0, pix_q.x};
  assign y16      = {7'd0, pix_q.y};
  assign accept   = (state == S_IDLE) && pixelWrite && pixelReady;
  assign oor      = (x16 > X_LAST) || (y16 > Y_LAST);
  assign LT24Rd_n = 1'b1;

  always_ff @(posedge clock)
    if (accept) pix_q <= {xAddr, yAddr, pixelData};

`ifdef LT24_PIXEL_STREAM_EN
  // Panel auto-increments inside the column window x..WIDTH-1, wrapping to winX on the next row.
  logic       win_vld_q, win_seq_q;
  logic [7:0] win_x_q, exp_x_q, org_x;
  logic [8:0] exp_y_q;

  assign stream_hit = win_vld_q && (pix_q.x == exp_x_q) && (pix_q.y == exp_y_q);
  assign org_x      = win_seq_q ? pix_q.x : win_x_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      win_vld_q <= 1'b0;
      win_seq_q <= 1'b0;
      win_x_q   <= '0;
      exp_x_q   <= '0;
      exp_y_q   <= '0;
    end else begin
      if (state == S_CHECK) win_seq_q <= !stream_hit;
      if (state == S_DONE) begin
        win_x_q <= org_x;
        if (x16 < X_LAST) begin
          exp_x_q   <= pix_q.x + 8'd1;
          exp_y_q   <= pix_q.y;
          win_vld_q <= 1'b1;
        end else if (y16 < Y_LAST) begin
          exp_x_q   <= org_x;
          exp_y_q   <= pix_q.y + 9'd1;
          win_vld_q <= 1'b1;
        end else begin
          win_vld_q <= 1'b0;
        end
      end
    end
  end
`else
  assign stream_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_d;
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    case (state)
      S_IDLE:  if (accept) state_d = S_CHECK;
      S_CHECK: begin
        if (oor) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WR_LO;
          cnt_d   = '0;
          slot_d  = stream_hit ? SLOT_PIX : 4'd0;
        end
      end
      S_WR_LO: begin
        if (cnt_q == LO_END) begin
          state_d = S_WR_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WR_HI: begin
        if (cnt_q == HI_END) begin
          cnt_d = '0;
          if (slot_q == SLOT_PIX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR_LO;
            slot_d  = slot_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so data, RS and the Wr_n fall share one edge.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    err_d   = (state == S_CHECK) && oor;
    wr_n_d  = (state_d != S_WR_LO);
    cs_n_d  = !((state_d == S_WR_LO) || (state_d == S_WR_HI));
    rs_d    = LT24RS;
    data_d  = LT24Data;
    if ((state_d == S_WR_LO) && (state != S_WR_LO)) begin
      case (slot_d)
        4'd0:    {rs_d, data_d} = {1'b0, 16'h002A};
        4'd1:    {rs_d, data_d} = {1'b1, 8'h00, x16[15:8]};
        4'd2:    {rs_d, data_d} = {1'b1, 8'h00, x16[7:0]};
        4'd3:    {rs_d, data_d} = {1'b1, 8'h00, X_LAST[15:8]};
        4'd4:    {rs_d, data_d} = {1'b1, 8'h00, X_LAST[7:0]};
        4'd5:    {rs_d, data_d} = {1'b0, 16'h002B};
        4'd6:    {rs_d, data_d} = {1'b1, 8'h00, y16[15:8]};
        4'd7:    {rs_d, data_d} = {1'b1, 8'h00, y16[7:0]};
        4'd8:    {rs_d, data_d} = {1'b1, 8'h00, Y_LAST[15:8]};
        4'd9:    {rs_d, data_d} = {1'b1, 8'h00, Y_LAST[7:0]};
        4'd10:   {rs_d, data_d} = {1'b0, 16'h002C};
        default: {rs_d, data_d} = {1'b1, pix_q.d};
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pixelReady <= 1'b0;
      addrError  <= 1'b0;
      LT24Wr_n   <= 1'b1;
      LT24CS_n   <= 1'b1;
      LT24RS     <= 1'b1;
      LT24Data   <= '0;
    end else begin
      pixelReady <= ready_d;
      addrError  <= err_d;
      LT24Wr_n   <= wr_n_d;
      LT24CS_n   <= cs_n_d;
      LT24RS     <= rs_d;
      LT24Data   <= data_d;
    end
  end
endmodule

// File: tb/tb_lt24_pixel_port.sv
// Scoreboard bench for lt24_pixel_port: expected bus words are queued by the stimulus and
// popped by a monitor on every Wr_n falling edge.
module tb_lt24_pixel_port;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady, addrError, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
  logic [15:0] LT24Data;

  lt24_pixel_port dut (
    .clock(clock), .reset(reset), .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady), .addrError(addrError),
    .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n), .LT24RS(LT24RS),
    .LT24Data(LT24Data)
  );

  always #5 clock = ~clock;

`ifdef LT24_PIXEL_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif

  // Hand-computed window sequence for pixel (5,7,0xF920)
  localparam logic [16:0] FIRST [12] = '{
    17'h0_002A, 17'h1_0000, 17'h1_0005, 17'h1_0000, 17'h1_00EF, 17'h0_002B,
    17'h1_0000, 17'h1_0007, 17'h1_0001, 17'h1_003F, 17'h0_002C, 17'h1_F920};

  int          n_cmp = 0, n_bad = 0;
  int          n_writes = 0, n_cs_low = 0, n_err = 0;
  logic [16:0] exp_q[$];
  logic [16:0] cap = '0;
  logic        prev_wr = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_wr && !LT24Wr_n) begin
        n_writes++;
        cap = {LT24RS, LT24Data};
        chk("cs_low_on_write", 32'(LT24CS_n), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got %h, required no write (t=%0t)", cap, $time);
        end else begin
          chk("bus_write", 32'(cap), 32'(exp_q.pop_front()));
        end
      end
      if (!prev_wr && LT24Wr_n) chk("data_hold", 32'({LT24RS, LT24Data}), 32'(cap));
      if (!LT24CS_n) n_cs_low++;
      if (addrError) n_err++;
    end
    prev_wr = LT24Wr_n;
  end

  task automatic push_window(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
    exp_q.push_back({1'b0, 16'h002A});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 8'h00, x});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'h00EF});
    exp_q.push_back({1'b0, 16'h002B});
    exp_q.push_back({1'b1, 15'h0000, y[8]});
    exp_q.push_back({1'b1, 8'h00, y[7:0]});
    exp_q.push_back({1'b1, 16'h0001});
    exp_q.push_back({1'b1, 16'h003F});
    exp_q.push_back({1'b0, 16'h002C});
    exp_q.push_back({1'b1, d});
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!pixelReady && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!pixelReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: pixelReady 0 after %0d cycles, required 1", t);
    end
  endtask

  // want_stream: the pixel continues the tracked run (streams only when the feature is built)
  task automatic send(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                      input bit want_stream, input bit prequeued, input string tag);
    int j, w0, e0, c0, per, nw;
    bit bad_addr;
    bad_addr = (x >= 8'd240) || (y >= 9'd320);
    wait_ready();
    w0 = n_writes; e0 = n_err; c0 = n_cs_low;
    if (bad_addr) begin
      per = 2; nw = 0;
    end else if (want_stream && STREAM) begin
      per = 7; nw = 1;
      if (!prequeued) exp_q.push_back({1'b1, d});
    end else begin
      per = 51; nw = 12;
      if (!prequeued) push_window(x, y, d);
    end
    xAddr = x; yAddr = y; pixelData = d; pixelWrite = 1'b1;
    @(posedge clock);
    #1 pixelWrite = 1'b0;
    j = 0;
    @(negedge clock);
    while (!pixelReady && j < 200) begin
      @(negedge clock);
      j++;
    end
    #1;
    chk({tag, "_period"}, 32'(j + 1), 32'(per));
    chk({tag, "_writes"}, 32'(n_writes - w0), 32'(nw));
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    if (bad_addr) begin
      chk({tag, "_addr_error_pulses"}, 32'(n_err - e0), 32'd1);
      chk({tag, "_cs_low_cycles"}, 32'(n_cs_low - c0), 32'd0);
    end else begin
      chk({tag, "_no_addr_error"}, 32'(n_err - e0), 32'd0);
    end
  endtask

  initial begin
    int t, w0;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      chk("reset_ctrl", 32'({pixelReady, addrError, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS}),
          32'(6'b001111));
      chk("reset_data", 32'(LT24Data), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("ready_after_release", 32'(pixelReady), 32'd1);

    foreach (FIRST[i]) exp_q.push_back(FIRST[i]);
    send(8'd5, 8'd7, 16'hF920, 1'b0, 1'b1, "first_window");
    send(8'd6, 9'd7, 16'h4DC4, 1'b1, 1'b0, "follow_up");
    for (int x = 7; x < 240; x++) send(8'(x), 9'd7, 16'(16'h1000 + x), 1'b1, 1'b0, "row_stream");
    send(8'd5, 9'd8, 16'hBEEF, 1'b1, 1'b0, "row_wrap");
    send(8'd0, 9'd8, 16'h0F0F, 1'b0, 1'b0, "rewindow");
    send(8'd240, 9'd0, 16'hDEAD, 1'b0, 1'b0, "oor_x");
    send(8'd0, 9'd320, 16'hDEAD, 1'b0, 1'b0, "oor_y");
    send(8'd1, 9'd8, 16'h5555, 1'b1, 1'b0, "after_oor");

    // Abort a windowed pixel while the tracker expects (6,7); reset must forget that.
    send(8'd5, 9'd7, 16'h1111, 1'b0, 1'b0, "pre_abort");
    wait_ready();
    w0 = n_writes;
    push_window(8'd100, 9'd200, 16'h1234);
    xAddr = 8'd100; yAddr = 9'd200; pixelData = 16'h1234; pixelWrite = 1'b1;
    @(posedge clock);
    #1 pixelWrite = 1'b0;
    t = 0;
    while (n_writes < w0 + 4 && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("abort_slot_reached", 32'(n_writes - w0), 32'd4);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_ctrl", 32'({pixelReady, addrError, LT24Wr_n, LT24CS_n, LT24RS}), 32'(5'b00111));
    chk("abort_data", 32'(LT24Data), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    chk("abort_writes_left", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    @(negedge clock);
    send(8'd6, 9'd7, 16'h4DC4, 1'b0, 1'b0, "post_reset");

    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule

// File: doc/lt24_pixel_port.md
# lt24_pixel_port

Responder end of the LT24 pixel interface (`xAddr`/`yAddr`/`pixelData`/`pixelWrite`/`pixelReady`) that game logic drives. Each accepted pixel becomes an 8080-style write sequence on the LT24 bus: a column/page window set followed by a memory-write command, then the 16-bit pixel. Sequential pixels are streamed as a single data write. The block sits between the game/pixel-generation logic and the LT24 panel pins.

## Interface
- `WIDTH`, 240, panel columns; valid x is 0..WIDTH-1
- `HEIGHT`, 320, panel rows; valid y is 0..HEIGHT-1
- `WR_LOW`, 2, cycles `LT24Wr_n` is held low per bus write (≥1)
- `WR_HIGH`, 2, cycles `LT24Wr_n` is held high per bus write (≥1)

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `xAddr` in 8: pixel column.
- `yAddr` in 9: pixel row.
- `pixelData` in 16: RGB565 pixel.
- `pixelWrite` in 1: request; a pixel is accepted on an edge where `pixelWrite && pixelReady`.
- `pixelReady` out 1: block can accept a pixel this cycle.
- `addrError` out 1: one-cycle pulse when an accepted pixel is out of range.
- `LT24Wr_n` out 1: write strobe, active low.
- `LT24Rd_n` out 1: constant 1.
- `LT24CS_n` out 1: chip select, active low.
- `LT24RS` out 1: 0 selects command, 1 selects data/parameter.
- `LT24Data` out 16: bus data.

## Operation
- Clocking and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - `pixelReady`=0, `addrError`=0.
  - `LT24Wr_n`=1, `LT24Rd_n`=1, `LT24CS_n`=1, `LT24RS`=1, `LT24Data`=0.
  - Window-valid flag cleared. FSM goes to IDLE.
- Accept: on acceptance, x, y and data are captured. `pixelReady` drops on the next edge.
- Out-of-range pixel (x≥WIDTH or y≥HEIGHT):
  - Pixel is dropped with no bus activity.
  - `addrError`=1 for one cycle.
  - Tracking state is unchanged.
  - `pixelReady` returns on the following cycle.
- Window sequence (12 bus writes, in order):
  - cmd 0x002A (RS=0)
  - x[15:8], x[7:0], (WIDTH-1)[15:8], (WIDTH-1)[7:0] (RS=1, upper byte 0)
  - cmd 0x002B (RS=0)
  - y hi, y lo, (HEIGHT-1) hi, (HEIGHT-1) lo (RS=1)
  - cmd 0x002C (RS=0)
  - pixel (RS=1)
  - After the sequence, the window origin is latched as winX=x, winY=y.
- Stream sequence (1 bus write): pixel only, RS=1.
- Tracking (updated after each written pixel (x,y)):
  - If x<WIDTH-1: expected next = (x+1, y).
  - Else if y<HEIGHT-1: expected next = (winX, y+1).
  - Else: the window-valid flag is cleared.
- FSM states:
  - IDLE: `pixelReady`=1, `CS_n`=1. On acceptance: go to CHECK.
  - CHECK: single cycle. Selects out-of-range drop (back to IDLE), stream, or window sequence. Loads the slot index.
  - WR_LO: `CS_n`=0, `Wr_n`=0. Lasts WR_LOW cycles.
  - WR_HI: `Wr_n`=1. Lasts WR_HIGH cycles. Then either the next slot (WR_LO) or DONE.
  - DONE: `CS_n`=1, tracking update. Goes to IDLE.
- `LT24Data`/`LT24RS` change only on entry to WR_LO and hold through WR_HI.
- Reset mid-sequence: abort immediately to reset values. The next pixel is always windowed.

## Timing
- Acceptance at edge N:
  - CHECK occupies cycle N+1.
  - The first WR_LO starts at N+2.
- A bus write occupies WR_LOW+WR_HIGH cycles. `CS_n` stays low continuously across all slots of one pixel.
- DONE is one cycle after the last WR_HI. `pixelReady` is high again the cycle after DONE.
- Pixel period with default parameters:
  - Stream: 1+1+4+1 = 7 cycles.
  - Window: 1+1+48+1 = 51 cycles.
  - Out of range: 2 cycles.
- The data/RS setup before the `Wr_n` falling edge is 0 cycles: both are registered on the same edge. The rising edge of `Wr_n` latches data in the panel.

## Configuration
- `LT24_PIXEL_STREAM_EN` defined:
  - Sequential-address detection and streaming are active.
  - The window-valid flag and the expected-address registers exist.
- `LT24_PIXEL_STREAM_EN` undefined:
  - Every in-range pixel uses the full 12-write window sequence.
  - No tracking registers are built.
  - Stream period behaviour is absent.

## Test plan
- Reset held 3 cycles, then released: all outputs at reset values during reset. `pixelReady`=1 on the first cycle after release.
- First pixel (5,7,0xF920): 12 writes in exact order 002A, 0000, 0005, 0000, 00EF, 002B, 0000, 0007, 0001, 003F, 002C, F920. RS pattern 0,1,1,1,1,0,1,1,1,1,0,1. Next ready at 51 cycles.
- Follow-up (6,7,0x4DC4) with the macro defined: single RS=1 write of 4DC4, 7-cycle period. With the macro undefined: the full 12 writes.
- Row wrap: window at (5,7), stream through (239,7), then (5,8): streamed. A following (0,8) is windowed.
- Out of range (240,0) and (0,320): no `Wr_n`/`CS_n` activity, one `addrError` pulse each, ready again after 2 cycles.
- Reset asserted in the 4th slot of a window sequence: bus returns to idle values on the next edge. The subsequent (6,7) is windowed, not streamed.
